// File: rtl/yarvi_lsu_seq.sv
// yarvi_lsu_seq: load/store sequencer between execute and the single-ported data memory.
// Define LSU_MISALIGNED_EN to split word-crossing accesses into two memory transactions.
module yarvi_lsu_seq (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        done,
    output logic        res_we,
    output logic [4:0]  res_rd,
    output logic [31:0] res_data,
    output logic        exc,
    output logic [31:0] exc_addr
);

`ifdef LSU_MISALIGNED_EN
    localparam bit MisalignedEn = 1'b1;
`else
    localparam bit MisalignedEn = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StCmd0, StWait0, StCmd1, StWait1, StDone} state_e;

    state_e      state_q, state_d;
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;
    logic        span_q;
    logic        exc_q;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic        mem_valid_q, mem_valid_d;

    logic        accept;
    logic [2:0]  req_width;
    logic        req_span;
    logic        req_illegal;
    logic        req_exc;

    // Request decode: access width, word-boundary crossing and legality.
    always_comb begin
        case (req_funct3[1:0])
            2'd0:    req_width = 3'd1;
            2'd1:    req_width = 3'd2;
            default: req_width = 3'd4;
        endcase
        req_span = ({1'b0, req_addr[1:0]} + req_width) > 3'd4;
        if (req_store) begin
            req_illegal = req_funct3 >= 3'd3;
        end else begin
            req_illegal = (req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11);
        end
        req_exc = req_illegal || (req_span && !MisalignedEn);
    end

    assign accept = (state_q == StIdle) && req_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            store_q  <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rd_q     <= 5'd0;
            span_q   <= 1'b0;
            exc_q    <= 1'b0;
        end else if (accept) begin
            store_q  <= req_store;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rd_q     <= req_rd;
            span_q   <= req_span;
            exc_q    <= req_exc;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    lo_d = 32'd0;
                    hi_d = 32'd0;
                    if (req_exc) begin
                        state_d = StDone;
                    end else begin
                        state_d     = StCmd0;
                        mem_valid_d = 1'b1;
                    end
                end
            end
            StCmd0: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    if (!store_q) begin
                        state_d = StWait0;
                    end else if (MisalignedEn && span_q) begin
                        state_d     = StCmd1;
                        mem_valid_d = 1'b1;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StWait0: begin
                if (mem_rvalid) begin
                    lo_d = mem_rdata;
                    if (MisalignedEn && span_q) begin
                        state_d     = StCmd1;
                        mem_valid_d = 1'b1;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StCmd1: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    state_d     = store_q ? StDone : StWait1;
                end
            end
            StWait1: begin
                if (mem_rvalid) begin
                    hi_d    = mem_rdata;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            mem_valid_q <= 1'b0;
            lo_q        <= 32'd0;
            hi_q        <= 32'd0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
        end
    end

    logic [3:0]  bytemask;
    logic [7:0]  strb8;
    logic [63:0] wdata64;
    logic        hi_half;
    logic [31:0] s;
    logic [31:0] load_val;

    // Command fields derive only from latched state, so they hold steady through a stall.
    always_comb begin
        case (funct3_q[1:0])
            2'd0:    bytemask = 4'b0001;
            2'd1:    bytemask = 4'b0011;
            default: bytemask = 4'b1111;
        endcase
        strb8   = {4'b0000, bytemask} << addr_q[1:0];
        wdata64 = {32'd0, wdata_q} << {addr_q[1:0], 3'b000};
        hi_half = (state_q == StCmd1);
        s       = 32'({hi_q, lo_q} >> {addr_q[1:0], 3'b000});
        case (funct3_q)
            3'd0:    load_val = {{24{s[7]}}, s[7:0]};
            3'd1:    load_val = {{16{s[15]}}, s[15:0]};
            3'd4:    load_val = {24'd0, s[7:0]};
            3'd5:    load_val = {16'd0, s[15:0]};
            default: load_val = s;
        endcase

        req_ready = (state_q == StIdle);
        mem_valid = mem_valid_q;
        mem_addr  = 32'd0;
        mem_we    = 1'b0;
        mem_wstrb = 4'd0;
        mem_wdata = 32'd0;
        if (mem_valid_q) begin
            mem_addr = {hi_half ? (addr_q[31:2] + 30'd1) : addr_q[31:2], 2'b00};
            mem_we   = store_q;
            if (store_q) begin
                mem_wstrb = hi_half ? strb8[7:4] : strb8[3:0];
                mem_wdata = hi_half ? wdata64[63:32] : wdata64[31:0];
            end
        end

        done     = (state_q == StDone);
        exc      = done && exc_q;
        exc_addr = exc ? addr_q : 32'd0;
        res_we   = done && !store_q && !exc_q;
        res_rd   = rd_q;
        res_data = res_we ? load_val : 32'd0;
    end

endmodule

// File: tb/tb_yarvi_lsu_seq.sv
// Scoreboard bench for yarvi_lsu_seq: expected commands/results are queued at issue time and
// popped by a monitor whenever the DUT fires a memory command or retires an operation.
module tb_yarvi_lsu_seq;
    logic        clock, reset_n;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        done, res_we, exc;
    logic [4:0]  res_rd;
    logic [31:0] res_data, exc_addr;

    typedef struct {
        string       name;
        int          t0;
        int          lat;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exc;
        logic [31:0] eaddr;
    } res_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } cmd_t;

    res_t res_q[$];
    cmd_t cmd_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stall_req = 0;
    int   rdelay = 0;

    yarvi_lsu_seq dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .done       (done),
        .res_we     (res_we),
        .res_rd     (res_rd),
        .res_data   (res_data),
        .exc        (exc),
        .exc_addr   (exc_addr)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Memory model: word store with strobes, reads answered rdelay+1 cycles after acceptance.
    initial begin
        logic [31:0] mem [bit [29:0]];
        logic [31:0] word, rword;
        logic        pend;
        int          cnt, stalled;
        mem[30'h40] = 32'h80FF7F00;
        mem[30'h3F] = 32'h44332211;
        mem_ready = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata = 32'd0;
        pend = 1'b0;
        cnt = 0;
        stalled = 0;
        rword = 32'd0;
        forever begin
            @(negedge clock);
            if (mem_valid && mem_ready) begin
                stalled = 0;
                word = mem.exists(mem_addr[31:2]) ? mem[mem_addr[31:2]] : 32'd0;
                if (mem_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_wstrb[b]) word[8*b +: 8] = mem_wdata[8*b +: 8];
                    end
                    mem[mem_addr[31:2]] = word;
                end else begin
                    pend = 1'b1;
                    cnt = rdelay;
                    rword = word;
                end
            end else if (mem_valid) begin
                stalled++;
            end
            @(posedge clock);
            #1;
            mem_rvalid = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = rword;
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
            mem_ready = (stalled >= stall_req);
        end
    end

    // Monitor: pops the scoreboard on every command fire and every retirement.
    initial begin
        res_t        e;
        cmd_t        c;
        logic        stalled_prev;
        logic [31:0] snap_addr, snap_wdata;
        logic [3:0]  snap_strb;
        stalled_prev = 1'b0;
        snap_addr = 32'd0;
        snap_wdata = 32'd0;
        snap_strb = 4'd0;
        forever begin
            @(negedge clock);
            if (mem_valid && stalled_prev) begin
                chk("stall addr stable", mem_addr, snap_addr);
                chk("stall strb stable", {28'd0, mem_wstrb}, {28'd0, snap_strb});
                chk("stall wdata stable", mem_wdata, snap_wdata);
            end
            stalled_prev = mem_valid && !mem_ready;
            snap_addr = mem_addr;
            snap_strb = mem_wstrb;
            snap_wdata = mem_wdata;
            if (mem_valid && mem_ready) begin
                if (cmd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected mem command: addr 0x%08h, required none", mem_addr);
                end else begin
                    c = cmd_q.pop_front();
                    chk("cmd addr", mem_addr, c.addr);
                    chk("cmd we", {31'd0, mem_we}, {31'd0, c.we});
                    chk("cmd wstrb", {28'd0, mem_wstrb}, {28'd0, c.strb});
                    if (c.we) chk("cmd wdata", mem_wdata, c.wdata);
                end
            end
            if (done) begin
                if (res_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected done: done 1, required 0");
                end else begin
                    e = res_q.pop_front();
                    chk({e.name, " latency"}, cyc - e.t0, e.lat);
                    chk({e.name, " res_we"}, {31'd0, res_we}, {31'd0, e.we});
                    chk({e.name, " exc"}, {31'd0, exc}, {31'd0, e.exc});
                    if (e.exc) chk({e.name, " exc_addr"}, exc_addr, e.eaddr);
                    if (e.we) begin
                        chk({e.name, " res_rd"}, {27'd0, res_rd}, {27'd0, e.rd});
                        chk({e.name, " res_data"}, res_data, e.data);
                    end
                end
            end
        end
    end

    task automatic push_cmd(input logic [31:0] a, input logic we, input logic [3:0] strb,
                            input logic [31:0] wd);
        cmd_t c;
        c.addr = a;
        c.we = we;
        c.strb = strb;
        c.wdata = wd;
        cmd_q.push_back(c);
    endtask

    task automatic issue(input string name, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                         input logic exp_we, input logic [31:0] exp_data, input logic exp_exc,
                         input int lat, input bit track);
        res_t e;
        int   n;
        @(posedge clock);
        #1;
        req_valid = 1'b1;
        req_store = st;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        req_rd = rd;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL %s accept timeout: req_ready 0, required 1", name);
        end else if (track) begin
            e.name = name;
            e.t0 = cyc;
            e.lat = lat;
            e.we = exp_we;
            e.rd = rd;
            e.data = exp_data;
            e.exc = exp_exc;
            e.eaddr = a;
            res_q.push_back(e);
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        chk({name, " req_ready after accept"}, {31'd0, req_ready}, 32'd0);
        if (track) begin
            n = 0;
            while (res_q.size() != 0 && n < 40) begin
                @(negedge clock);
                n++;
            end
            if (res_q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL %s done timeout: no done within 40 cycles, required done", name);
                res_q.delete();
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, " mem_valid"}, {31'd0, mem_valid}, 32'd0);
        chk({tag, " mem_addr"}, mem_addr, 32'd0);
        chk({tag, " done"}, {31'd0, done}, 32'd0);
        chk({tag, " res_we"}, {31'd0, res_we}, 32'd0);
        chk({tag, " exc"}, {31'd0, exc}, 32'd0);
        chk({tag, " res_data"}, res_data, 32'd0);
        chk({tag, " exc_addr"}, exc_addr, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = 1'b0;
        req_store = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        req_rd = 5'd0;
        repeat (2) @(negedge clock);
        check_idle_outputs("reset");
        @(negedge clock);
        reset_n = 1'b1;

        push_cmd(32'h100, 1'b0, 4'h0, 32'h0);
        issue("LB 0x101", 1'b0, 3'd0, 32'h101, 32'h0, 5'd5, 1'b1, 32'h0000007F, 1'b0, 3, 1'b1);
        push_cmd(32'h100, 1'b1, 4'hF, 32'hBEEF1234);
        issue("SW 0x100", 1'b1, 3'd2, 32'h100, 32'hBEEF1234, 5'd0, 1'b0, 32'h0, 1'b0, 2, 1'b1);
        push_cmd(32'h100, 1'b0, 4'h0, 32'h0);
        issue("LHU 0x102", 1'b0, 3'd5, 32'h102, 32'h0, 5'd6, 1'b1, 32'h0000BEEF, 1'b0, 3, 1'b1);
        push_cmd(32'h100, 1'b0, 4'h0, 32'h0);
        issue("LH 0x102", 1'b0, 3'd1, 32'h102, 32'h0, 5'd7, 1'b1, 32'hFFFFBEEF, 1'b0, 3, 1'b1);
        push_cmd(32'h200, 1'b1, 4'h8, 32'hA5000000);
        issue("SB 0x203", 1'b1, 3'd0, 32'h203, 32'h000000A5, 5'd9, 1'b0, 32'h0, 1'b0, 2, 1'b1);

        stall_req = 2;
        push_cmd(32'h200, 1'b0, 4'h0, 32'h0);
        issue("LW 0x200 stalled", 1'b0, 3'd2, 32'h200, 32'h0, 5'd10, 1'b1, 32'hA5000000, 1'b0,
              5, 1'b1);
        stall_req = 0;

        push_cmd(32'h100, 1'b1, 4'hF, 32'h88776655);
        issue("SW 0x100 b", 1'b1, 3'd2, 32'h100, 32'h88776655, 5'd0, 1'b0, 32'h0, 1'b0, 2, 1'b1);
`ifdef LSU_MISALIGNED_EN
        push_cmd(32'h0FC, 1'b0, 4'h0, 32'h0);
        push_cmd(32'h100, 1'b0, 4'h0, 32'h0);
        issue("LW 0x0FE", 1'b0, 3'd2, 32'h0FE, 32'h0, 5'd11, 1'b1, 32'h66554433, 1'b0, 5, 1'b1);
        push_cmd(32'hFFFFFFFC, 1'b1, 4'h8, 32'hAA000000);
        push_cmd(32'h00000000, 1'b1, 4'h7, 32'h00DDCCBB);
        issue("SW 0xFFFFFFFF", 1'b1, 3'd2, 32'hFFFFFFFF, 32'hDDCCBBAA, 5'd0, 1'b0, 32'h0, 1'b0,
              3, 1'b1);
`else
        issue("LW 0x0FE", 1'b0, 3'd2, 32'h0FE, 32'h0, 5'd11, 1'b0, 32'h0, 1'b1, 1, 1'b1);
        issue("SW 0xFFFFFFFF", 1'b1, 3'd2, 32'hFFFFFFFF, 32'hDDCCBBAA, 5'd0, 1'b0, 32'h0, 1'b1,
              1, 1'b1);
`endif
        push_cmd(32'h100, 1'b0, 4'h0, 32'h0);
        issue("LB 0x103", 1'b0, 3'd0, 32'h103, 32'h0, 5'd13, 1'b1, 32'hFFFFFF88, 1'b0, 3, 1'b1);
        push_cmd(32'h100, 1'b0, 4'h0, 32'h0);
        issue("LBU 0x103", 1'b0, 3'd4, 32'h103, 32'h0, 5'd14, 1'b1, 32'h00000088, 1'b0, 3, 1'b1);
        issue("illegal load f3=3", 1'b0, 3'd3, 32'h100, 32'h0, 5'd12, 1'b0, 32'h0, 1'b1, 1, 1'b1);
        issue("illegal store f3=4", 1'b1, 3'd4, 32'h104, 32'h0, 5'd0, 1'b0, 32'h0, 1'b1, 1, 1'b1);

        // Reset during WAIT0 with the read answer arriving after release.
        rdelay = 2;
        push_cmd(32'h100, 1'b0, 4'h0, 32'h0);
        issue("LW reset victim", 1'b0, 3'd2, 32'h100, 32'h0, 5'd16, 1'b0, 32'h0, 1'b0, 0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_idle_outputs("mid-op reset");
        @(negedge clock);
        reset_n = 1'b1;
        repeat (6) @(negedge clock);
        rdelay = 0;

        push_cmd(32'h0FC, 1'b0, 4'h0, 32'h0);
        issue("LW 0x0FC after reset", 1'b0, 3'd2, 32'h0FC, 32'h0, 5'd15, 1'b1, 32'h44332211, 1'b0,
              3, 1'b1);

        repeat (3) @(negedge clock);
        chk("result queue drained", res_q.size(), 32'd0);
        chk("command queue drained", cmd_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
